// File: rtl/maj_dot_seq.sv
// Streams a common vector in, then computes MAJ_PC_NUM dot products against weight-memory rows.
// Optional saturating arithmetic under `MAJ_SAT_EN; the default build wraps modulo 2^FP_SIZE.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | waiting for start
// S_LOAD    | capturing PC_NUM common-vector elements
// S_COMPUTE | issuing PC_NUM weight reads, then one drain cycle
// S_OUT     | presenting row result until res_ready
// S_DONE    | one-cycle done pulse
module maj_dot_seq #(
  parameter int FP_SIZE    = 64,
  parameter int PC_NUM     = 32,
  parameter int MAJ_PC_NUM = 10
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   busy,
  input  logic                                   cv_valid,
  output logic                                   cv_ready,
  input  logic [FP_SIZE-1:0]                     cv_data,
  output logic                                   w_rd,
  output logic [$clog2(MAJ_PC_NUM*PC_NUM)-1:0]   w_addr,
  input  logic [FP_SIZE-1:0]                     w_data,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [FP_SIZE-1:0]                     res_data,
  output logic [$clog2(MAJ_PC_NUM)-1:0]          res_idx,
  output logic                                   done
);
  localparam int AW = $clog2(MAJ_PC_NUM*PC_NUM);
  localparam int IW = $clog2(MAJ_PC_NUM);
  localparam int JW = (PC_NUM > 1) ? $clog2(PC_NUM) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_OUT     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [JW-1:0] J_LAST = JW'(PC_NUM - 1);
  localparam logic [IW-1:0] I_LAST = IW'(MAJ_PC_NUM - 1);

  logic [2:0]         state;
  logic [FP_SIZE-1:0] cv_buf [PC_NUM];
  logic [JW-1:0]      j, j_d;
  logic [IW-1:0]      i;
  logic               issued, rd_d;
  logic [FP_SIZE-1:0] acc, acc_next;

  assign busy      = (state != S_IDLE);
  assign cv_ready  = (state == S_LOAD);
  assign w_rd      = (state == S_COMPUTE) && !issued;
  assign w_addr    = w_rd ? (AW'(i) * AW'(PC_NUM) + AW'(j)) : '0;
  assign res_valid = (state == S_OUT);
  assign res_data  = res_valid ? acc : '0;
  assign res_idx   = res_valid ? i : '0;
  assign done      = (state == S_DONE);

`ifdef MAJ_SAT_EN
  localparam logic [FP_SIZE-1:0] SMAX = {1'b0, {(FP_SIZE-1){1'b1}}};
  localparam logic [FP_SIZE-1:0] SMIN = {1'b1, {(FP_SIZE-1){1'b0}}};
  logic signed [2*FP_SIZE-1:0] prod_full;
  logic [FP_SIZE-1:0]          prod_sat;
  logic [FP_SIZE:0]            sum_full;
  logic                        prod_ovf, sum_ovf, sat_sticky;

  always_comb begin
    prod_full = $signed(cv_buf[j_d]) * $signed(w_data);
    prod_ovf  = (prod_full[2*FP_SIZE-1:FP_SIZE-1] != {(FP_SIZE+1){prod_full[2*FP_SIZE-1]}});
    prod_sat  = prod_ovf ? (prod_full[2*FP_SIZE-1] ? SMIN : SMAX) : prod_full[FP_SIZE-1:0];
    sum_full  = {acc[FP_SIZE-1], acc} + {prod_sat[FP_SIZE-1], prod_sat};
    sum_ovf   = (sum_full[FP_SIZE] != sum_full[FP_SIZE-1]);
    acc_next  = sum_ovf ? (sum_full[FP_SIZE] ? SMIN : SMAX) : sum_full[FP_SIZE-1:0];
  end

  // Sticky flag restarts with the first read of every row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       sat_sticky <= 1'b0;
    else if (w_rd && (j == '0))       sat_sticky <= 1'b0;
    else if (rd_d && (prod_ovf || sum_ovf)) sat_sticky <= 1'b1;
  end
`else
  logic [FP_SIZE-1:0] prod;
  assign prod     = cv_buf[j_d] * w_data;
  assign acc_next = acc + prod;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      i      <= '0;
      j      <= '0;
      j_d    <= '0;
      issued <= 1'b0;
      rd_d   <= 1'b0;
      acc    <= '0;
      for (int k = 0; k < PC_NUM; k++) cv_buf[k] <= '0;
    end else begin
      rd_d <= w_rd;
      j_d  <= j;
      // Read data lands one cycle after each w_rd, including the drain cycle.
      if (rd_d) acc <= acc_next;
      case (state)
        S_IDLE: if (start) begin
          state <= S_LOAD;
          j     <= '0;
        end
        S_LOAD: if (cv_valid) begin
          cv_buf[j] <= cv_data;
          if (j == J_LAST) begin
            j      <= '0;
            i      <= '0;
            issued <= 1'b0;
            acc    <= '0;
            state  <= S_COMPUTE;
          end else begin
            j <= j + JW'(1);
          end
        end
        S_COMPUTE: begin
          if (!issued) begin
            if (j == J_LAST) begin
              j      <= '0;
              issued <= 1'b1;
            end else begin
              j <= j + JW'(1);
            end
          end else begin
            state <= S_OUT;
          end
        end
        S_OUT: if (res_ready) begin
          if (i == I_LAST) begin
            state <= S_DONE;
          end else begin
            i      <= i + IW'(1);
            issued <= 1'b0;
            acc    <= '0;
            state  <= S_COMPUTE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maj_dot_seq.sv
// Directed bench for maj_dot_seq with FP_SIZE=16, PC_NUM=4, MAJ_PC_NUM=2.
module tb_maj_dot_seq;
  localparam int W = 16;
  localparam int N = 4;
  localparam int M = 2;

  logic clk = 0, reset = 1, start = 0, cv_valid = 0, res_ready = 0;
  logic cv_ready, busy, w_rd, res_valid, done;
  logic [W-1:0] cv_data = '0, w_data = '0, res_data;
  logic [2:0] w_addr;
  logic [0:0] res_idx;
  logic [W-1:0] wmem [8];

  int passed = 0, total = 0;
  int cyc = 0, t_first = 0, lat = 0, done_cnt = 0, wrd_cnt = 0, viol = 0;
  logic wrd_p = 0, rv_p = 0;
  logic [W-1:0] log_data [$];
  logic [0:0]   log_idx  [$];
  logic [2:0]   addr_log [$];

  maj_dot_seq #(.FP_SIZE(W), .PC_NUM(N), .MAJ_PC_NUM(M)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .cv_valid(cv_valid), .cv_ready(cv_ready), .cv_data(cv_data),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (w_rd) w_data <= wmem[w_addr];
  end

  always @(negedge clk) begin
    wrd_p <= w_rd;
    rv_p  <= res_valid;
    if (w_rd) begin
      addr_log.push_back(w_addr);
      wrd_cnt <= wrd_cnt + 1;
    end
    if (w_rd && !wrd_p) t_first <= cyc;
    if (res_valid && !rv_p) lat <= cyc - t_first;
    if (res_valid && res_ready) begin
      log_data.push_back(res_data);
      log_idx.push_back(res_idx);
    end
    if (done) done_cnt <= done_cnt + 1;
    if ((w_rd && res_valid) || (w_rd && cv_ready) || (cv_ready && res_valid)) viol <= viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_basic_weights();
    wmem[0] = 16'd1; wmem[1] = 16'd1; wmem[2] = 16'd1; wmem[3] = 16'd1;
    wmem[4] = 16'd2; wmem[5] = 16'd0; wmem[6] = 16'hFFFF; wmem[7] = 16'd1;
  endtask

  task automatic start_job();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic load_cv(input logic [4*W-1:0] v, input bit toggle, output int taken);
    int k = 0;
    bit ph = 1;
    for (int g = 0; g < 40 && k < N; g++) begin
      cv_valid = toggle ? ph : 1'b1;
      cv_data  = cv_valid ? v[k*W +: W] : 16'hDEAD;
      if (cv_valid && cv_ready) k++;
      ph = ~ph;
      tick();
    end
    cv_valid = 0;
    taken = k;
  endtask

  task automatic finish_job(input int budget);
    int d0 = done_cnt;
    bit ok = 0;
    res_ready = 1;
    for (int g = 0; g < budget; g++) begin
      if (done_cnt > d0) begin
        ok = 1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) $display("FAIL job_timeout: done not seen within %0d cycles", budget);
    else passed++;
    tick();
  endtask

  localparam logic [4*W-1:0] CV_BASIC = {16'd4, 16'd3, 16'd2, 16'd1};

  task automatic test_reset();
    reset = 1; #2 reset = 0; #2;
    total++;
    if ({busy, cv_ready, w_rd, res_valid, done} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {busy, cv_ready, w_rd, res_valid, done});
    else passed++;
    total++;
    if ({w_addr, res_data, res_idx} !== 20'b0)
      $display("FAIL reset_data: got %h want 0", {w_addr, res_data, res_idx});
    else passed++;
    start = 1;
    tick(); tick();
    total++;
    if (busy !== 1'b0) $display("FAIL start_in_reset: busy %b want 0", busy);
    else passed++;
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    start = 0;
    total++;
    if (busy !== 1'b1 || cv_ready !== 1'b1)
      $display("FAIL start_after_release: busy %b cv_ready %b want 1 1", busy, cv_ready);
    else passed++;
    reset = 0; #1;
    total++;
    if (busy !== 1'b0 || cv_ready !== 1'b0)
      $display("FAIL abort_in_load: busy %b cv_ready %b want 0 0", busy, cv_ready);
    else passed++;
    #2 reset = 1;
    tick();
  endtask

  task automatic test_basic();
    int base = log_data.size();
    int a0 = addr_log.size();
    int d0 = done_cnt;
    int taken;
    bit addr_ok = 1;
    set_basic_weights();
    start_job();
    load_cv(CV_BASIC, 0, taken);
    finish_job(60);
    total++;
    if (log_data.size() != base + 2) $display("FAIL basic_count: got %0d want 2", log_data.size() - base);
    else passed++;
    total++;
    if (log_data.size() < base + 2 || log_data[base] !== 16'd10 || log_idx[base] !== 1'b0)
      $display("FAIL basic_row0: got %0d idx %0d want 10 idx 0",
               (log_data.size() > base) ? log_data[base] : 16'hx, (log_idx.size() > base) ? log_idx[base] : 1'bx);
    else passed++;
    total++;
    if (log_data.size() < base + 2 || log_data[base+1] !== 16'd3 || log_idx[base+1] !== 1'b1)
      $display("FAIL basic_row1: got %0d idx %0d want 3 idx 1",
               (log_data.size() > base + 1) ? log_data[base+1] : 16'hx, (log_idx.size() > base + 1) ? log_idx[base+1] : 1'bx);
    else passed++;
    total++;
    if (done_cnt - d0 != 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0);
    else passed++;
    total++;
    if (lat != N + 1) $display("FAIL row_latency: got %0d want %0d", lat, N + 1);
    else passed++;
    if (addr_log.size() != a0 + 8) addr_ok = 0;
    else for (int k = 0; k < 8; k++) if (addr_log[a0+k] !== 3'(k)) addr_ok = 0;
    total++;
    if (!addr_ok) $display("FAIL w_addr_seq: got %0d reads want 8 in order 0..7", addr_log.size() - a0);
    else passed++;
  endtask

  task automatic test_backpressure();
    int base = log_data.size();
    int taken, wc;
    bit seen = 0, stable = 1;
    set_basic_weights();
    res_ready = 0;
    start_job();
    load_cv(CV_BASIC, 0, taken);
    for (int g = 0; g < 30; g++) begin
      if (res_valid) begin
        seen = 1;
        break;
      end
      tick();
    end
    wc = wrd_cnt;
    for (int g = 0; g < 5; g++) begin
      if (res_valid !== 1'b1 || res_data !== 16'd10 || res_idx !== 1'b0 || w_rd !== 1'b0) stable = 0;
      tick();
    end
    total++;
    if (!seen || !stable)
      $display("FAIL stall_hold: res_valid %b data %0d idx %0d want 1 10 0", res_valid, res_data, res_idx);
    else passed++;
    total++;
    if (wrd_cnt != wc) $display("FAIL stall_no_rd: got %0d reads want 0", wrd_cnt - wc);
    else passed++;
    finish_job(60);
    total++;
    if (log_data.size() != base + 2 || log_data[base] !== 16'd10 || log_data[base+1] !== 16'd3)
      $display("FAIL stall_results: got %0d results want 10,3", log_data.size() - base);
    else passed++;
  endtask

  task automatic test_load_stall();
    int base = log_data.size();
    int taken;
    set_basic_weights();
    start_job();
    load_cv(CV_BASIC, 1, taken);
    finish_job(60);
    total++;
    if (taken != N) $display("FAIL load_taken: got %0d want %0d", taken, N);
    else passed++;
    total++;
    if (log_data.size() != base + 2 || log_data[base] !== 16'd10 || log_data[base+1] !== 16'd3)
      $display("FAIL load_stall_results: got %0d results want 10,3", log_data.size() - base);
    else passed++;
  endtask

  task automatic test_overflow();
    int base = log_data.size();
    int taken;
    logic [W-1:0] exp_v;
`ifdef MAJ_SAT_EN
    exp_v = 16'd32767;
`else
    exp_v = 16'd4;
`endif
    for (int k = 0; k < 8; k++) wmem[k] = 16'd32767;
    start_job();
    load_cv({4{16'd32767}}, 0, taken);
    finish_job(60);
    total++;
    if (log_data.size() != base + 2 || log_data[base] !== exp_v || log_data[base+1] !== exp_v)
      $display("FAIL overflow: got %0d want %0d", (log_data.size() > base) ? log_data[base] : 16'hx, exp_v);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int base, d0, taken;
    bit hit = 0;
    set_basic_weights();
    res_ready = 1;
    start_job();
    load_cv(CV_BASIC, 0, taken);
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (w_rd && w_addr == 3'd5) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) $display("FAIL mid_reach: row1 second read not seen");
    else passed++;
    base = log_data.size();
    d0 = done_cnt;
    reset = 0; #1;
    total++;
    if ({busy, cv_ready, w_rd, res_valid, done, w_addr, res_data, res_idx} !== 25'b0)
      $display("FAIL mid_reset_outputs: got %h want 0", {busy, cv_ready, w_rd, res_valid, done, w_addr, res_data, res_idx});
    else passed++;
    tick(); tick();
    reset = 1;
    for (int g = 0; g < 8; g++) tick();
    total++;
    if (done_cnt != d0 || log_data.size() != base || busy !== 1'b0)
      $display("FAIL mid_abandon: done %0d results %0d busy %b want 0 0 0", done_cnt - d0, log_data.size() - base, busy);
    else passed++;
    start_job();
    load_cv(CV_BASIC, 0, taken);
    finish_job(60);
    total++;
    if (log_data.size() != base + 2 || log_data[base] !== 16'd10 || log_data[base+1] !== 16'd3)
      $display("FAIL mid_restart: got %0d results want 10,3", log_data.size() - base);
    else passed++;
  endtask

  task automatic test_start_busy();
    int base = log_data.size();
    int d0 = done_cnt;
    int taken;
    set_basic_weights();
    start_job();
    load_cv(CV_BASIC, 0, taken);
    tick();
    start = 1;
    tick();
    start = 0;
    finish_job(60);
    for (int g = 0; g < 6; g++) tick();
    total++;
    if (log_data.size() != base + 2 || done_cnt - d0 != 1)
      $display("FAIL start_busy: results %0d done %0d want 2 1", log_data.size() - base, done_cnt - d0);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL start_busy_idle: busy %b want 0", busy);
    else passed++;
    total++;
    if (viol != 0) $display("FAIL handshake_exclusive: got %0d overlaps want 0", viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_load_stall();
    test_overflow();
    test_reset_mid();
    test_start_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end
endmodule

// File: doc/maj_dot_seq.md
MAJ_DOT_SEQ -- requirements
Module: maj_dot_seq

Interface
REQ-001 SHALL have parameter FP_SIZE, default 64, meaning operand/accumulator width (signed two's complement).
REQ-002 SHALL have parameter PC_NUM, default 32, meaning common-vector length (elements per dot product).
REQ-003 SHALL have parameter MAJ_PC_NUM, default 10, meaning number of rows (dot products per job).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-007 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-008 SHALL have ports cv_valid input 1, cv_ready output 1, cv_data input FP_SIZE: common-vector element stream.
REQ-009 SHALL have ports w_rd output 1, w_addr output $clog2(MAJ_PC_NUM*PC_NUM), w_data input FP_SIZE: weight-memory read port, fixed 1-cycle read latency.
REQ-010 SHALL have ports res_valid output 1, res_ready input 1, res_data output FP_SIZE, res_idx output $clog2(MAJ_PC_NUM): result stream.
REQ-011 SHALL have port done  output  1  single-cycle pulse at job completion.

Function
REQ-012 SHALL implement states IDLE, LOAD, COMPUTE, OUT, DONE.
REQ-013 IDLE: start=1 -> LOAD next cycle; start outside IDLE SHALL be ignored.
REQ-014 LOAD: cv_ready=1; each cycle with cv_valid&cv_ready stores cv_data at index j (0..PC_NUM-1), j increments; after beat PC_NUM-1 -> COMPUTE with row i=0.
REQ-015 COMPUTE: SHALL assert w_rd for PC_NUM consecutive cycles with w_addr=i*PC_NUM+j, j=0..PC_NUM-1, no gaps.
REQ-016 w_data returned one cycle after each w_rd SHALL be accumulated: acc = acc + cv[j]*w_data; acc cleared to 0 on entry to each row.
REQ-017 Arithmetic: product and sum SHALL be taken modulo 2^FP_SIZE (low FP_SIZE bits of signed result) unless MAJ_SAT_EN defined.
REQ-018 Row latency: res_valid SHALL rise exactly PC_NUM+1 cycles after the row's first w_rd.
REQ-019 OUT: res_valid=1, res_data=acc, res_idx=i, all stable until res_ready=1; no w_rd issued while in OUT.
REQ-020 OUT with res_ready=1: i<MAJ_PC_NUM-1 -> COMPUTE with i+1; i=MAJ_PC_NUM-1 -> DONE.
REQ-021 DONE: done=1 for one cycle, then IDLE; cv buffer retained but SHALL be reloaded by the next job.
REQ-022 cv_ready SHALL be 0 outside LOAD; w_rd SHALL be 0 outside COMPUTE; res_valid SHALL be 0 outside OUT.
REQ-023 cv_valid deasserted in LOAD SHALL stall the FSM with no element lost or duplicated.
REQ-024 res_ready high while res_valid low SHALL have no effect.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, counters i/j=0, acc=0 regardless of clk.
REQ-026 During and after reset: busy, cv_ready, w_rd, res_valid, done SHALL be 0; w_addr, res_data, res_idx SHALL be 0.
REQ-027 Reset asserted mid-job SHALL abandon the job; no res_valid or done SHALL follow until a new start.
REQ-028 Deassertion SHALL be followed by IDLE; start accepted on first rising edge after deassertion.

Configuration
REQ-029 Macro MAJ_SAT_EN defined: each product and each accumulation SHALL saturate to [-2^(FP_SIZE-1), 2^(FP_SIZE-1)-1]; sticky bit cleared per row, no extra latency.
REQ-030 MAJ_SAT_EN undefined: wrap-around arithmetic per REQ-017; no saturation logic present.

Verification (bench params FP_SIZE=16, PC_NUM=4, MAJ_PC_NUM=2)
REQ-031 Basic: cv=1,2,3,4; row0 w=1,1,1,1; row1 w=2,0,-1,1; res_ready=1 -> res (idx0,10),(idx1,3), then done pulse.
REQ-032 Backpressure: as REQ-031 with res_ready held 0 for 5 cycles in OUT -> res_data=10, res_idx=0 held stable, no w_rd during stall.
REQ-033 LOAD stall: cv_valid toggles 1,0,1,0,... -> exactly 4 elements captured, results identical to REQ-031.
REQ-034 Overflow: cv=32767 x4, w=32767 x4 -> without MAJ_SAT_EN wrapped 16-bit value 4; with MAJ_SAT_EN res_data=32767.
REQ-035 Reset mid-COMPUTE: reset=0 on row1's second w_rd -> all outputs 0 at once, FSM IDLE, no done; new start completes normally.
REQ-036 Start during busy: pulse start in COMPUTE -> ignored, exactly 2 results and 1 done.
